// File: rtl/spi_sclk_sequencer.sv
// Frame sequencer for the SPI clock generator: validates and loads the SCLK divisor,
// frames chip-select with setup/hold gaps and emits per-half-period launch/capture ticks.
module spi_sclk_sequencer #(
    parameter int FRAME_BITS = 8,
    parameter int SETUP_CYC  = 2,
    parameter int HOLD_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] div_req,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cs_n,
    output logic [7:0] gen_divisor,
    output logic       gen_ld,
    output logic       gen_en,
    output logic       half_tick,
    output logic       lead_edge,
    output logic [4:0] bit_idx
);
    typedef enum logic [2:0] {IDLE, LOAD, SETUP, RUN, HOLD, DONE} state_e;

    localparam logic [5:0] TICK_LAST  = 6'(2 * FRAME_BITS - 1);
    localparam logic [4:0] BIT_LAST   = 5'(FRAME_BITS - 1);
    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

    state_e     state_q;
    logic       busy_q, done_q, err_q, cs_n_q, gen_ld_q, gen_en_q, half_tick_q, lead_edge_q;
    logic [7:0] gen_div_q;
    logic [4:0] bit_idx_q;
    logic [6:0] hc_q;
    logic [5:0] tcnt_q;
    logic [7:0] gap_q;

    // An odd or zero divisor would make clock_Gen pass clk straight through.
    logic       div_ok;
    logic [6:0] hc_last;
    assign div_ok  = ~div_req[0] && (div_req != 8'd0);
    assign hc_last = gen_div_q[7:1] - 7'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            gen_div_q   <= 8'd0;
            gen_ld_q    <= 1'b0;
            gen_en_q    <= 1'b0;
            half_tick_q <= 1'b0;
            lead_edge_q <= 1'b0;
            bit_idx_q   <= 5'd0;
            hc_q        <= 7'd0;
            tcnt_q      <= 6'd0;
            gap_q       <= 8'd0;
        end else begin
            gen_ld_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            half_tick_q <= 1'b0;
            if (abort && state_q != IDLE) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                cs_n_q      <= 1'b1;
                gen_en_q    <= 1'b0;
                lead_edge_q <= 1'b0;
                bit_idx_q   <= 5'd0;
                hc_q        <= 7'd0;
                tcnt_q      <= 6'd0;
                gap_q       <= 8'd0;
            end else begin
                case (state_q)
                    IDLE: if (start && !abort) begin
                        if (div_ok) begin
                            state_q   <= LOAD;
                            gen_div_q <= div_req;
                            cs_n_q    <= 1'b0;
                            busy_q    <= 1'b1;
                            gen_ld_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    LOAD: begin
                        state_q <= SETUP;
                        gap_q   <= 8'd0;
                    end
                    SETUP: if (gap_q == SETUP_LAST) begin
                        gap_q    <= 8'd0;
                        hc_q     <= 7'd0;
                        gen_en_q <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                    RUN: if (hc_q == hc_last) begin
                        hc_q        <= 7'd0;
                        half_tick_q <= 1'b1;
                        lead_edge_q <= ~tcnt_q[0];
                        if (tcnt_q == TICK_LAST) begin
                            tcnt_q   <= 6'd0;
                            gen_en_q <= 1'b0;
                            gap_q    <= 8'd0;
                            state_q  <= HOLD;
                        end else begin
                            tcnt_q <= tcnt_q + 6'd1;
                        end
                    end else begin
                        hc_q <= hc_q + 7'd1;
                    end
                    HOLD: if (gap_q == HOLD_LAST) begin
                        gap_q   <= 8'd0;
                        cs_n_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
                // bit_idx advances the cycle after a trailing tick, so it is stable across both ticks of a bit.
                if (half_tick_q && !lead_edge_q)
                    bit_idx_q <= (bit_idx_q == BIT_LAST) ? 5'd0 : bit_idx_q + 5'd1;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cs_n        = cs_n_q;
    assign gen_divisor = gen_div_q;
    assign gen_ld      = gen_ld_q;
    assign gen_en      = gen_en_q;
    assign half_tick   = half_tick_q;
    assign lead_edge   = lead_edge_q;
    assign bit_idx     = bit_idx_q;
endmodule
